// File: rtl/mycpu_pkg.sv
// mycpu_pkg: definitions shared by the instruction-fetch front end.
//   fetch_state_t : 2-bit encoding of the fetch controller FSM
//   RESET_VECTOR  : first fetch address after reset
//   EXC_VECTOR    : common exception entry point
//   is_misaligned : word-alignment test on a fetch address
package mycpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hbfc0_0380;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stat_cnt.sv
// fetch_stat_cnt: free-running stall-cycle counter for the fetch front end.
// Only instantiated when FETCH_STAT_EN is defined.
//   clk : clock
//   rst : synchronous active-high reset, clears the count
//   en  : count this cycle
//   cnt : current count, wraps 32'hffff_ffff -> 0
module fetch_stat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: IF stage controller. Issues one instruction-SRAM request
// at a time, buffers a returned word while ID is stalled, squashes data that
// returns after a flush, and produces the registered IF/ID payload.
//
// Build option: FETCH_STAT_EN -- when defined, fetch_stall_cnt counts cycles
// with if_stall=1; when undefined it is tied to 0 and no counter exists.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   pc, pc_exp        : fetch address and its misalignment flag
//   flush             : redirect (exception / ERET) this cycle
//   id_stall          : ID cannot accept a new instruction
//   inst_req/addr     : SRAM request valid / address (= pc)
//   inst_addr_ok      : SRAM accepted the request
//   inst_data_ok/rdata: SRAM read data valid / data
//   if_stall          : holds the PC stage
//   id_valid/pc/inst/adel : registered IF/ID payload
//   fetch_stall_cnt   : stall-cycle statistic
//
// State table
//   state   | meaning
//   IDLE    | first cycle after reset, no request
//   REQ     | presenting pc to SRAM (or delivering an address error)
//   WAIT    | request accepted, waiting for data (cancel => discard it)
//   HOLD    | data returned while ID stalled, word kept in hold register
module inst_fetch_ctrl
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_exp,
  input  logic        flush,
  input  logic        id_stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel,
  output logic [31:0] fetch_stall_cnt
);

  fetch_state_t state_q, state_d;
  logic         cancel_q, cancel_d;
  logic [31:0]  hold_q, hold_d;
  logic         deliver;
  logic [31:0]  word;
  logic         in_flight;

  assign inst_addr = pc;

  always_comb begin
    state_d   = state_q;
    cancel_d  = cancel_q;
    hold_d    = hold_q;
    inst_req  = 1'b0;
    deliver   = 1'b0;
    word      = '0;
    in_flight = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (pc_exp) begin
          // address error is delivered straight away, SRAM untouched
          deliver = 1'b1;
        end else begin
          inst_req = 1'b1;
          if (inst_addr_ok) begin
            state_d   = ST_WAIT;
            in_flight = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (inst_data_ok) begin
          if (cancel_q) begin
            cancel_d = 1'b0;
            state_d  = ST_REQ;
          end else if (!id_stall) begin
            deliver = 1'b1;
            word    = inst_rdata;
            state_d = ST_REQ;
          end else begin
            hold_d  = inst_rdata;
            state_d = ST_HOLD;
          end
        end else begin
          in_flight = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!id_stall) begin
          deliver = 1'b1;
          word    = hold_q;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect overrides everything; a request the SRAM still owes us
    // must be drained in WAIT and thrown away.
    if (flush) begin
      state_d  = in_flight ? ST_WAIT : ST_REQ;
      cancel_d = in_flight;
    end

    if (rst) begin
      inst_req = 1'b0;
      deliver  = 1'b0;
    end

    if_stall = rst | ~(deliver | flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cancel_q <= 1'b0;
      hold_q   <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
      id_adel  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      hold_q   <= hold_d;
      if (flush) begin
        id_valid <= 1'b0;
        id_adel  <= 1'b0;
      end else if (deliver) begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_inst  <= word;
        id_adel  <= pc_exp;
      end else if (!id_stall) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STAT_EN
  fetch_stat_cnt u_stat (
    .clk (clk),
    .rst (rst),
    .en  (if_stall),
    .cnt (fetch_stall_cnt)
  );
`else
  assign fetch_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed scenarios followed by randomized traffic,
// all compared each cycle against a transaction-level reference model.
// Honors FETCH_STAT_EN the same way as the design.
module tb_inst_fetch_ctrl;
  import mycpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_exp;
  logic        flush;
  logic        id_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;
  logic [31:0] fetch_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_exp          (pc_exp),
    .flush           (flush),
    .id_stall        (id_stall),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .if_stall        (if_stall),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_adel         (id_adel),
    .fetch_stall_cnt (fetch_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a request is either unissued, outstanding (possibly
  // cancelled), or its word is parked in a one-deep queue waiting for ID.
  bit          m_fresh;
  bit          m_out;
  bit          m_cancel;
  logic [31:0] m_held_q[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_adel;
  logic [31:0] m_cnt;
  bit          m_last_stall;

  // One clock cycle: combinational outputs checked at negedge, model
  // advanced and registered outputs checked just after posedge.
  task automatic step();
    bit ready, exp_req, dlv, from_held, from_data, exp_stall, inflight;
    logic [31:0] w;
    @(negedge clk);
    ready     = !rst && !m_fresh && !m_out && (m_held_q.size() == 0);
    exp_req   = ready && !pc_exp;
    dlv       = 1'b0;
    from_held = 1'b0;
    from_data = 1'b0;
    w         = '0;
    if (!rst) begin
      if (ready && pc_exp) begin
        dlv = 1'b1;
      end else if (m_out && !m_cancel && inst_data_ok && !id_stall) begin
        dlv = 1'b1; from_data = 1'b1; w = inst_rdata;
      end else if (m_held_q.size() != 0 && !id_stall) begin
        dlv = 1'b1; from_held = 1'b1; w = m_held_q[0];
      end
    end
    exp_stall = rst || !(dlv || flush);
    chk("inst_req", 32'(inst_req), 32'(exp_req));
    chk("inst_addr", inst_addr, pc);
    chk("if_stall", 32'(if_stall), 32'(exp_stall));
    m_last_stall = exp_stall;

    @(posedge clk);
    #1;
    if (rst) begin
      m_fresh = 1; m_out = 0; m_cancel = 0; m_held_q.delete();
      m_valid = 0; m_pc = '0; m_inst = '0; m_adel = 0; m_cnt = '0;
    end else begin
      inflight = (exp_req && inst_addr_ok) || (m_out && !inst_data_ok);
      if (flush) begin
        m_held_q.delete();
        m_out = inflight; m_cancel = inflight;
        m_valid = 0; m_adel = 0;
      end else begin
        if (dlv) begin
          m_valid = 1; m_pc = pc; m_inst = w; m_adel = pc_exp;
        end else if (!id_stall) begin
          m_valid = 0;
        end
        if (from_held) void'(m_held_q.pop_front());
        if (m_out && inst_data_ok) begin
          if (m_cancel) m_cancel = 0;
          else if (!from_data) m_held_q.push_back(inst_rdata);
          m_out = 0;
        end
        if (exp_req && inst_addr_ok) m_out = 1;
      end
      m_fresh = 0;
`ifdef FETCH_STAT_EN
      if (exp_stall) m_cnt = m_cnt + 32'd1;
`endif
    end
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("id_pc", id_pc, m_pc);
    chk("id_inst", id_inst, m_inst);
    chk("id_adel", 32'(id_adel), 32'(m_adel));
    chk("stall_cnt", fetch_stall_cnt, m_cnt);
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc     = v;
    pc_exp = is_misaligned(v);
  endtask

  logic [31:0] base_cnt;
  logic [31:0] exp_delta;

  initial begin
    rst = 1; flush = 0; id_stall = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    set_pc(RESET_VECTOR);
    m_fresh = 1; m_out = 0; m_cancel = 0;
    m_valid = 0; m_pc = '0; m_inst = '0; m_adel = 0; m_cnt = '0;
    m_last_stall = 1;

    // reset
    step(); step();
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_cnt", fetch_stall_cnt, 32'd0);

    // basic fetch at the reset vector
    rst = 0;
    #1 chk("idle_req", 32'(inst_req), 32'd0);
    step();
    chk("to_req", 32'(dut.state_q), 32'(ST_REQ));
    inst_addr_ok = 1;
    #1 chk("req_addr", inst_addr, 32'hbfc0_0000);
    chk("req_valid", 32'(inst_req), 32'd1);
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h2408_0001;
    #1 chk("dok_if_stall", 32'(if_stall), 32'd0);
    step();
    chk("f1_valid", 32'(id_valid), 32'd1);
    chk("f1_pc", id_pc, 32'hbfc0_0000);
    chk("f1_inst", id_inst, 32'h2408_0001);

    // id_stall for 3 cycles across data_ok
    inst_data_ok = 0; set_pc(32'hbfc0_0004);
    id_stall = 1; inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h2409_0002;
    #1 chk("wait_stall", 32'(if_stall), 32'd1);
    step();
    chk("hold_state", 32'(dut.state_q), 32'(ST_HOLD));
    chk("hold_inst", id_inst, 32'h2408_0001);
    inst_data_ok = 0;
    #1 chk("hold_if_stall", 32'(if_stall), 32'd1);
    step();
    chk("hold_state2", 32'(dut.state_q), 32'(ST_HOLD));
    chk("hold_pc", id_pc, 32'hbfc0_0000);
    id_stall = 0;
    #1 chk("hold_release", 32'(if_stall), 32'd0);
    step();
    chk("held_inst", id_inst, 32'h2409_0002);
    chk("held_pc", id_pc, 32'hbfc0_0004);

    // flush with a request in flight
    set_pc(32'hbfc0_0008); inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; flush = 1;
    step();
    chk("flush_valid", 32'(id_valid), 32'd0);
    flush = 0; set_pc(EXC_VECTOR); inst_data_ok = 1; inst_rdata = 32'hdead_beef;
    #1 chk("cancel_noreq", 32'(inst_req), 32'd0);
    step();
    chk("discard_valid", 32'(id_valid), 32'd0);
    inst_data_ok = 0; inst_addr_ok = 1;
    #1 chk("exc_req", 32'(inst_req), 32'd1);
    chk("exc_addr", inst_addr, 32'hbfc0_0380);
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h2410_0003;
    step();
    chk("exc_inst", id_inst, 32'h2410_0003);
    inst_data_ok = 0;

    // misaligned pc
    set_pc(32'hbfc0_0002);
    #1 chk("adel_noreq", 32'(inst_req), 32'd0);
    step();
    chk("adel_flag", 32'(id_adel), 32'd1);
    chk("adel_inst", id_inst, 32'd0);
    chk("adel_pc", id_pc, 32'hbfc0_0002);

    // addr_ok withheld for 5 cycles
    set_pc(32'hbfc0_0010);
    base_cnt = m_cnt;
    for (int i = 0; i < 5; i++) begin
      #1 chk("slow_req", 32'(inst_req), 32'd1);
      chk("slow_addr", inst_addr, 32'hbfc0_0010);
      chk("slow_stall", 32'(if_stall), 32'd1);
      step();
    end
`ifdef FETCH_STAT_EN
    exp_delta = 32'd5;
`else
    exp_delta = 32'd0;
`endif
    chk("stat_delta", fetch_stall_cnt - base_cnt, exp_delta);
`ifndef FETCH_STAT_EN
    chk("stat_zero", fetch_stall_cnt, 32'd0);
`endif

    // reset during WAIT, then a stray data_ok
    inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; rst = 1;
    step();
    chk("rw_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 0; inst_data_ok = 1; inst_rdata = 32'h1234_5678;
    step();
    chk("rw_state2", 32'(dut.state_q), 32'(ST_REQ));
    chk("rw_valid", 32'(id_valid), 32'd0);
    step();
    chk("rw_valid2", 32'(id_valid), 32'd0);
    inst_data_ok = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      id_stall     = ($urandom_range(0, 2) == 0);
      inst_addr_ok = $urandom_range(0, 1);
      inst_data_ok = $urandom_range(0, 1);
      inst_rdata   = $urandom;
      if (!m_last_stall || $urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 7) == 0) set_pc($urandom);
        else set_pc({$urandom_range(0, 32'h3fff_ffff), 2'b00});
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
